mem_loader: RTL and testbench
=============================

MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, word-address width (4096 words).
REQ-002 SHALL have parameter WORD_COUNT, default 4096, number of 32-bit words in a full image.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low, sampled on rising clk.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a load.
REQ-006 SHALL have port flush  input  1  end of image; pad and write any partial word, then finish.
REQ-007 SHALL have port byte_valid  input  1  byte_data holds a valid image byte.
REQ-008 SHALL have port byte_data  input  8  image byte, in file order.
REQ-009 SHALL have port byte_ready  output  1  loader accepts byte this cycle.
REQ-010 SHALL have port mem_we  output  1  one-cycle word write strobe to instruction memory.
REQ-011 SHALL have port mem_addr  output  ADDR_W  word address of the current write.
REQ-012 SHALL have port mem_wdata  output  32  assembled word.
REQ-013 SHALL have port core_rst_n  output  1  active-low reset held on the core until load completes.
REQ-014 SHALL have port busy  output  1  high in LOAD or WRITE.
REQ-015 SHALL have port done  output  1  high in DONE.
REQ-016 SHALL have port words_loaded  output  ADDR_W+1  count of words written this load.

Function
REQ-017 SHALL implement states IDLE, LOAD, WRITE, DONE.
REQ-018 IDLE: byte_ready=0; start=1 -> LOAD, clear byte index, mem_addr, words_loaded, assembly register.
REQ-019 LOAD: byte_ready=1; a byte transfers when byte_valid && byte_ready.
REQ-020 Byte k (k=0..3) of a word SHALL land in mem_wdata[8k+:8] (little-endian lane order).
REQ-021 On the transfer of byte 3 -> WRITE; byte index wraps to 0.
REQ-022 WRITE: exactly one cycle, mem_we=1, byte_ready=0, mem_addr/mem_wdata stable.
REQ-023 Leaving WRITE: words_loaded+1; if it reaches WORD_COUNT -> DONE, else mem_addr+1 and -> LOAD.
REQ-024 mem_addr SHALL NOT wrap; last write address is WORD_COUNT-1.
REQ-025 flush in LOAD with byte index 0 -> DONE, no write.
REQ-026 flush in LOAD with byte index 1..3 -> unfilled lanes zeroed, -> WRITE, then DONE regardless of count.
REQ-027 flush and a byte transfer in the same cycle: byte accepted first, then flush applied to the updated index.
REQ-028 flush in IDLE, WRITE or DONE SHALL be ignored (in WRITE, the pending write completes normally).
REQ-029 start while busy SHALL be ignored; start in DONE SHALL restart a load (-> LOAD, counters cleared, core_rst_n=0).
REQ-030 core_rst_n SHALL be 0 in IDLE, LOAD, WRITE and 1 only in DONE.
REQ-031 mem_we SHALL be 0 in every state except WRITE.
REQ-032 byte_valid in IDLE, WRITE, DONE SHALL NOT be consumed.

Reset
REQ-033 rst_n=0 at a rising edge -> IDLE next cycle, from any state.
REQ-034 Reset values: byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, core_rst_n=0, busy=0, done=0, words_loaded=0.
REQ-035 Reset mid-word or mid-WRITE SHALL discard the partial word; no mem_we on the reset edge or after.

Verification
REQ-036 WORD_COUNT=2, start, bytes 13,00,00,00,93,00,10,00 continuous -> writes addr0=00000013, addr1=00100093, done=1, core_rst_n=1, words_loaded=2.
REQ-037 Bytes EF,BE,AD,DE with byte_valid gapped every other cycle -> single mem_we at addr0, wdata=DEADBEEF; byte_ready=0 only in WRITE cycle.
REQ-038 Bytes AA,BB then flush -> one write wdata=0000BBAA, then DONE; flush after byte 3 word at index 0 -> no extra write.
REQ-039 rst_n=0 after 2 bytes of word 5 -> IDLE, core_rst_n=0, no write at addr5; new start reloads from addr0.
REQ-040 start pulsed during LOAD, and flush in IDLE -> no state change, counters unaffected.
REQ-041 Full default image of 4096 words -> last mem_we at addr FFF, words_loaded=4096, done and core_rst_n rise the cycle after that write.

Source files
------------

// File: rtl/mem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot-image loader.
// master drives bytes and observes writes; slave is the loader itself.
interface mem_loader_if #(
    parameter int unsigned ADDR_W = 12
);
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

    modport slave (
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );
endinterface

// File: rtl/mem_loader.sv
// Assembles a little-endian byte stream into 32-bit words, writes them to instruction
// memory at ascending addresses and holds the core in reset until the image is loaded.
module mem_loader #(
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned WORD_COUNT = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              flush,
    mem_loader_if.slave       bus,
    output logic              core_rst_n,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StLoad  = 2'd1;
    localparam logic [1:0] StWrite = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    localparam logic [ADDR_W:0] FullCount = WORD_COUNT[ADDR_W:0];

    logic [1:0]        state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              flush_pend_q, flush_pend_d;

    logic              xfer;
    logic [1:0]        idx_upd;
    logic [31:0]       wdata_upd;
    logic [31:0]       keep_mask;

    // Byte accepted this cycle is merged before any flush decision looks at the index.
    always_comb begin
        xfer      = (state_q == StLoad) && bus.byte_valid;
        idx_upd   = idx_q + {1'b0, xfer};
        wdata_upd = wdata_q;
        if (xfer) begin
            wdata_upd[{idx_q, 3'b000} +: 8] = bus.byte_data;
        end
    end

    // Lanes at or above the fill index are unfilled and padded with zero on flush.
    always_comb begin
        keep_mask = 32'hFFFF_FFFF;
        unique case (idx_upd)
            2'd1:    keep_mask = 32'h0000_00FF;
            2'd2:    keep_mask = 32'h0000_FFFF;
            2'd3:    keep_mask = 32'h00FF_FFFF;
            default: keep_mask = 32'hFFFF_FFFF;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        count_d      = count_q;
        flush_pend_d = flush_pend_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d      = StLoad;
                    idx_d        = 2'd0;
                    addr_d       = '0;
                    wdata_d      = '0;
                    count_d      = '0;
                    flush_pend_d = 1'b0;
                end
            end

            StLoad: begin
                idx_d   = idx_upd;
                wdata_d = wdata_upd;
                if (xfer && (idx_q == 2'd3)) begin
                    // A coincident flush lands on index 0: finish after this write.
                    state_d      = StWrite;
                    flush_pend_d = flush;
                end else if (flush) begin
                    if (idx_upd == 2'd0) begin
                        state_d = StDone;
                    end else begin
                        wdata_d      = wdata_upd & keep_mask;
                        idx_d        = 2'd0;
                        state_d      = StWrite;
                        flush_pend_d = 1'b1;
                    end
                end
            end

            StWrite: begin
                count_d      = count_q + (ADDR_W + 1)'(1);
                flush_pend_d = 1'b0;
                if (flush_pend_q || (count_d == FullCount)) begin
                    state_d = StDone;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = StLoad;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            idx_q        <= 2'd0;
            addr_q       <= '0;
            wdata_q      <= '0;
            count_q      <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            count_q      <= count_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    assign bus.byte_ready = (state_q == StLoad);
    assign bus.mem_we     = (state_q == StWrite);
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;
    assign busy           = (state_q == StLoad) || (state_q == StWrite);
    assign done           = (state_q == StDone);
    assign core_rst_n     = (state_q == StDone);
    assign words_loaded   = count_q;

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: a two-word instance for the short image and a
// default-size instance for everything else, including the full 4096-word load.
module tb_mem_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        rst_n_a, start_a, flush_a, core_rst_n_a, busy_a, done_a;
    logic [12:0] wl_a;
    logic        rst_n_b, start_b, flush_b, core_rst_n_b, busy_b, done_b;
    logic [12:0] wl_b;

    mem_loader_if #(.ADDR_W(12)) bus_a ();
    mem_loader_if #(.ADDR_W(12)) bus_b ();

    mem_loader #(.ADDR_W(12), .WORD_COUNT(2)) dut_a (
        .clk(clk), .rst_n(rst_n_a), .start(start_a), .flush(flush_a), .bus(bus_a),
        .core_rst_n(core_rst_n_a), .busy(busy_a), .done(done_a), .words_loaded(wl_a)
    );

    mem_loader #(.ADDR_W(12), .WORD_COUNT(4096)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .start(start_b), .flush(flush_b), .bus(bus_b),
        .core_rst_n(core_rst_n_b), .busy(busy_b), .done(done_b), .words_loaded(wl_b)
    );

    logic [11:0] wa_a[$];
    logic [31:0] wd_a[$];
    logic [11:0] wa_b[$];
    logic [31:0] wd_b[$];
    int cyc_b = 0;
    int last_we_cyc_b = -1;
    int first_done_cyc_b = -1;
    int viol_b = 0;

    always @(negedge clk) begin
        cyc_b++;
        if (bus_a.mem_we === 1'b1) begin
            wa_a.push_back(bus_a.mem_addr);
            wd_a.push_back(bus_a.mem_wdata);
        end
        if (bus_b.mem_we === 1'b1) begin
            wa_b.push_back(bus_b.mem_addr);
            wd_b.push_back(bus_b.mem_wdata);
            last_we_cyc_b = cyc_b;
        end
        if (done_b === 1'b1 && first_done_cyc_b < 0) first_done_cyc_b = cyc_b;
        if (busy_b === 1'b1 && bus_b.byte_ready !== 1'b1 && bus_b.mem_we !== 1'b1) viol_b++;
        if (bus_b.byte_ready === 1'b1 && bus_b.mem_we === 1'b1) viol_b++;
    end

    function automatic logic [31:0] word_exp(input int i);
        logic [11:0] a;
        a = i[11:0];
        return {4'hA, a, 4'h5, a};
    endfunction

    task automatic clear_b();
        wa_b.delete();
        wd_b.delete();
        viol_b = 0;
    endtask

    task automatic pulse_start_b();
        @(negedge clk); start_b = 1'b1;
        @(negedge clk); start_b = 1'b0;
    endtask

    task automatic pulse_flush_b();
        @(negedge clk); flush_b = 1'b1;
        @(negedge clk); flush_b = 1'b0;
    endtask

    task automatic reset_b();
        @(negedge clk); rst_n_b = 1'b0; bus_b.byte_valid = 1'b0; flush_b = 1'b0;
        @(negedge clk); rst_n_b = 1'b1;
    endtask

    task automatic send_b(input logic [7:0] b, input logic fl);
        int n = 0;
        @(negedge clk);
        bus_b.byte_valid = 1'b1;
        bus_b.byte_data  = b;
        flush_b          = fl;
        while (bus_b.byte_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            total++; bad++;
            $display("FAIL send_b_ready_timeout got byte_ready=%b required 1", bus_b.byte_ready);
        end
    endtask

    task automatic idle_b();
        @(negedge clk); bus_b.byte_valid = 1'b0; flush_b = 1'b0;
    endtask

    task automatic send_a(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        bus_a.byte_valid = 1'b1;
        bus_a.byte_data  = b;
        while (bus_a.byte_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            total++; bad++;
            $display("FAIL send_a_ready_timeout got byte_ready=%b required 1", bus_a.byte_ready);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n_a = 1'b0; rst_n_b = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        total++; if (bus_b.byte_ready !== 1'b0) begin bad++; $display("FAIL rst_byte_ready got %b required 0", bus_b.byte_ready); end
        total++; if (bus_b.mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_we got %b required 0", bus_b.mem_we); end
        total++; if (bus_b.mem_addr !== 12'h000) begin bad++; $display("FAIL rst_mem_addr got %h required 000", bus_b.mem_addr); end
        total++; if (bus_b.mem_wdata !== 32'h0) begin bad++; $display("FAIL rst_mem_wdata got %h required 00000000", bus_b.mem_wdata); end
        total++; if (core_rst_n_b !== 1'b0) begin bad++; $display("FAIL rst_core_rst_n got %b required 0", core_rst_n_b); end
        total++; if (busy_b !== 1'b0) begin bad++; $display("FAIL rst_busy got %b required 0", busy_b); end
        total++; if (done_b !== 1'b0) begin bad++; $display("FAIL rst_done got %b required 0", done_b); end
        total++; if (wl_b !== 13'd0) begin bad++; $display("FAIL rst_words_loaded got %0d required 0", wl_b); end
        total++; if ({busy_a, done_a, core_rst_n_a} !== 3'b000) begin bad++; $display("FAIL rst_small got %b required 000", {busy_a, done_a, core_rst_n_a}); end
        @(negedge clk);
        rst_n_a = 1'b1; rst_n_b = 1'b1;
    endtask

    task automatic test_small_image();
        logic [7:0] img [8];
        img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        wa_a.delete(); wd_a.delete();
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        for (int k = 0; k < 8; k++) send_a(img[k]);
        @(negedge clk); bus_a.byte_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        total++; if (wa_a.size() !== 2) begin bad++; $display("FAIL small_write_count got %0d required 2", wa_a.size()); end
        if (wa_a.size() >= 2) begin
            total++; if (wa_a[0] !== 12'h000 || wd_a[0] !== 32'h0000_0013) begin bad++; $display("FAIL small_write0 got %h:%h required 000:00000013", wa_a[0], wd_a[0]); end
            total++; if (wa_a[1] !== 12'h001 || wd_a[1] !== 32'h0010_0093) begin bad++; $display("FAIL small_write1 got %h:%h required 001:00100093", wa_a[1], wd_a[1]); end
        end
        total++; if (done_a !== 1'b1 || core_rst_n_a !== 1'b1) begin bad++; $display("FAIL small_done got done=%b core_rst_n=%b required 1 1", done_a, core_rst_n_a); end
        total++; if (wl_a !== 13'd2) begin bad++; $display("FAIL small_words_loaded got %0d required 2", wl_a); end
    endtask

    task automatic test_gapped();
        logic [7:0] img [4];
        img = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        clear_b();
        pulse_start_b();
        for (int k = 0; k < 4; k++) begin
            send_b(img[k], 1'b0);
            idle_b();
        end
        repeat (3) @(negedge clk);
        #1;
        total++; if (wa_b.size() !== 1) begin bad++; $display("FAIL gap_write_count got %0d required 1", wa_b.size()); end
        if (wa_b.size() >= 1) begin
            total++; if (wa_b[0] !== 12'h000 || wd_b[0] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL gap_write got %h:%h required 000:deadbeef", wa_b[0], wd_b[0]); end
        end
        total++; if (viol_b !== 0) begin bad++; $display("FAIL gap_ready_outside_write got %0d required 0", viol_b); end
        total++; if (busy_b !== 1'b1 || wl_b !== 13'd1) begin bad++; $display("FAIL gap_state got busy=%b wl=%0d required 1 1", busy_b, wl_b); end
        // Word-aligned flush: finish with no extra write.
        pulse_flush_b();
        repeat (2) @(negedge clk);
        #1;
        total++; if (wa_b.size() !== 1) begin bad++; $display("FAIL aligned_flush_writes got %0d required 1", wa_b.size()); end
        total++; if (done_b !== 1'b1 || wl_b !== 13'd1) begin bad++; $display("FAIL aligned_flush_done got done=%b wl=%0d required 1 1", done_b, wl_b); end
    endtask

    task automatic test_flush_partial();
        logic [7:0] img [6];
        img = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB};
        clear_b();
        pulse_start_b();
        total++; if (busy_b !== 1'b1 || core_rst_n_b !== 1'b0 || wl_b !== 13'd0) begin bad++; $display("FAIL restart_from_done got busy=%b core=%b wl=%0d required 1 0 0", busy_b, core_rst_n_b, wl_b); end
        for (int k = 0; k < 6; k++) send_b(img[k], 1'b0);
        @(negedge clk); bus_b.byte_valid = 1'b0; flush_b = 1'b1;
        @(negedge clk); flush_b = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        total++; if (wa_b.size() !== 2) begin bad++; $display("FAIL partial_write_count got %0d required 2", wa_b.size()); end
        if (wa_b.size() >= 2) begin
            total++; if (wd_b[0] !== 32'h4433_2211) begin bad++; $display("FAIL partial_word0 got %h required 44332211", wd_b[0]); end
            total++; if (wa_b[1] !== 12'h001 || wd_b[1] !== 32'h0000_BBAA) begin bad++; $display("FAIL partial_word1 got %h:%h required 001:0000bbaa", wa_b[1], wd_b[1]); end
        end
        total++; if (done_b !== 1'b1 || core_rst_n_b !== 1'b1 || wl_b !== 13'd2) begin bad++; $display("FAIL partial_done got done=%b core=%b wl=%0d required 1 1 2", done_b, core_rst_n_b, wl_b); end
    endtask

    task automatic test_flush_same_cycle();
        clear_b();
        pulse_start_b();
        for (int k = 1; k <= 5; k++) send_b(8'(k), 1'b0);
        send_b(8'h06, 1'b1);
        idle_b();
        repeat (3) @(negedge clk);
        #1;
        total++; if (wa_b.size() !== 2) begin bad++; $display("FAIL samecyc_write_count got %0d required 2", wa_b.size()); end
        if (wa_b.size() >= 2) begin
            total++; if (wd_b[1] !== 32'h0000_0605) begin bad++; $display("FAIL samecyc_word got %h required 00000605", wd_b[1]); end
        end
        total++; if (done_b !== 1'b1 || wl_b !== 13'd2) begin bad++; $display("FAIL samecyc_done got done=%b wl=%0d required 1 2", done_b, wl_b); end
    endtask

    task automatic test_ignore();
        pulse_flush_b();
        repeat (2) @(negedge clk);
        #1;
        total++; if (done_b !== 1'b1 || busy_b !== 1'b0 || wl_b !== 13'd2) begin bad++; $display("FAIL flush_in_done got done=%b busy=%b wl=%0d required 1 0 2", done_b, busy_b, wl_b); end
        clear_b();
        pulse_start_b();
        send_b(8'hA1, 1'b0);
        send_b(8'hA2, 1'b0);
        idle_b();
        pulse_start_b();
        send_b(8'hA3, 1'b0);
        send_b(8'hA4, 1'b0);
        idle_b();
        repeat (3) @(negedge clk);
        #1;
        total++; if (wa_b.size() !== 1) begin bad++; $display("FAIL start_in_load_writes got %0d required 1", wa_b.size()); end
        if (wa_b.size() >= 1) begin
            total++; if (wd_b[0] !== 32'hA4A3_A2A1) begin bad++; $display("FAIL start_in_load_word got %h required a4a3a2a1", wd_b[0]); end
        end
        total++; if (wl_b !== 13'd1) begin bad++; $display("FAIL start_in_load_count got %0d required 1", wl_b); end
        reset_b();
        pulse_flush_b();
        repeat (2) @(negedge clk);
        #1;
        total++; if (busy_b !== 1'b0 || done_b !== 1'b0 || wl_b !== 13'd0) begin bad++; $display("FAIL flush_in_idle got busy=%b done=%b wl=%0d required 0 0 0", busy_b, done_b, wl_b); end
    endtask

    task automatic test_reset_mid();
        clear_b();
        pulse_start_b();
        for (int k = 0; k < 22; k++) send_b(8'(k), 1'b0);
        @(negedge clk); bus_b.byte_valid = 1'b0; rst_n_b = 1'b0;
        @(negedge clk); rst_n_b = 1'b1;
        #1;
        total++; if (wa_b.size() !== 5) begin bad++; $display("FAIL rstmid_write_count got %0d required 5", wa_b.size()); end
        if (wa_b.size() >= 5) begin
            total++; if (wa_b[4] !== 12'h004 || wd_b[4] !== 32'h1312_1110) begin bad++; $display("FAIL rstmid_word4 got %h:%h required 004:13121110", wa_b[4], wd_b[4]); end
        end
        total++; if (busy_b !== 1'b0 || core_rst_n_b !== 1'b0 || wl_b !== 13'd0 || bus_b.mem_addr !== 12'h000) begin
            bad++; $display("FAIL rstmid_state got busy=%b core=%b wl=%0d addr=%h required 0 0 0 000", busy_b, core_rst_n_b, wl_b, bus_b.mem_addr);
        end
        pulse_start_b();
        for (int k = 0; k < 4; k++) send_b(8'(8'hC0 + k), 1'b0);
        idle_b();
        repeat (3) @(negedge clk);
        #1;
        total++; if (wa_b.size() !== 6) begin bad++; $display("FAIL rstmid_reload_count got %0d required 6", wa_b.size()); end
        if (wa_b.size() >= 6) begin
            total++; if (wa_b[5] !== 12'h000 || wd_b[5] !== 32'hC3C2_C1C0) begin bad++; $display("FAIL rstmid_reload got %h:%h required 000:c3c2c1c0", wa_b[5], wd_b[5]); end
        end
    endtask

    task automatic test_full_image();
        logic [31:0] w;
        int errs;
        int n;
        reset_b();
        clear_b();
        first_done_cyc_b = -1;
        pulse_start_b();
        for (int i = 0; i < 4096; i++) begin
            w = word_exp(i);
            for (int j = 0; j < 4; j++) send_b(w[8*j +: 8], 1'b0);
        end
        idle_b();
        n = 0;
        while (done_b !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        #1;
        total++; if (done_b !== 1'b1) begin bad++; $display("FAIL full_done_timeout got done=%b required 1", done_b); end
        total++; if (wa_b.size() !== 4096) begin bad++; $display("FAIL full_write_count got %0d required 4096", wa_b.size()); end
        errs = 0;
        for (int i = 0; i < wa_b.size() && i < 4096; i++) begin
            if (wa_b[i] !== 12'(i) || wd_b[i] !== word_exp(i)) errs++;
        end
        total++; if (errs !== 0) begin bad++; $display("FAIL full_contents got %0d bad words required 0", errs); end
        if (wa_b.size() >= 1) begin
            total++; if (wa_b[wa_b.size()-1] !== 12'hFFF) begin bad++; $display("FAIL full_last_addr got %h required fff", wa_b[wa_b.size()-1]); end
        end
        total++; if (wl_b !== 13'd4096 || core_rst_n_b !== 1'b1) begin bad++; $display("FAIL full_status got wl=%0d core=%b required 4096 1", wl_b, core_rst_n_b); end
        total++; if (first_done_cyc_b !== last_we_cyc_b + 1) begin bad++; $display("FAIL full_done_timing got cycle %0d required %0d", first_done_cyc_b, last_we_cyc_b + 1); end
        total++; if (viol_b !== 0) begin bad++; $display("FAIL full_ready_outside_write got %0d required 0", viol_b); end
    endtask

    initial begin
        rst_n_a = 1'b0; start_a = 1'b0; flush_a = 1'b0;
        rst_n_b = 1'b0; start_b = 1'b0; flush_b = 1'b0;
        bus_a.byte_valid = 1'b0; bus_a.byte_data = 8'h00;
        bus_b.byte_valid = 1'b0; bus_b.byte_data = 8'h00;
        test_reset();
        test_small_image();
        test_gapped();
        test_flush_partial();
        test_flush_same_cycle();
        test_ignore();
        test_reset_mid();
        test_full_image();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
